// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision adder datapath:
// field widths, alignment FSM states and operand field extractors.
package fp16_pkg;

   localparam int LARG_EXP   = 5;
   localparam int LARG_MANT  = 10;
   localparam int LARG_FP    = 1 + LARG_EXP + LARG_MANT;
   localparam int MAX_DESLOC = 12;
   localparam int LARG_CONT  = $clog2(MAX_DESLOC + 1);

   typedef enum logic [1:0] {
      IDLE,
      COMPARA,
      DESLOCA,
      PRONTO
   } estado_t;

   function automatic logic sinal_de(input logic [LARG_FP-1:0] op);
      return op[LARG_FP-1];
   endfunction

   function automatic logic [LARG_EXP-1:0] expoente_de(input logic [LARG_FP-1:0] op);
      return op[LARG_FP-2 -: LARG_EXP];
   endfunction

   function automatic logic [LARG_MANT-1:0] fracao_de(input logic [LARG_FP-1:0] op);
      return op[LARG_MANT-1:0];
   endfunction

endpackage

// File: rtl/compara_expoente.sv
// Combinational front end of the alignment stage: picks the larger-exponent
// operand, restores hidden bits and computes the capped shift count.
module compara_expoente
   import fp16_pkg::*;
(
   input  logic [LARG_FP-1:0]    op_a,
   input  logic [LARG_FP-1:0]    op_b,
   output logic                  troca,
   output logic                  sinal_maior,
   output logic                  sinal_menor,
   output logic [LARG_EXP-1:0]   exp_maior,
   output logic [LARG_MANT+1:0]  mant_maior,
   output logic [LARG_MANT+1:0]  mant_menor,
   output logic [LARG_CONT-1:0]  cont
);

   logic [LARG_FP-1:0]  maior;
   logic [LARG_FP-1:0]  menor;
   logic [LARG_EXP-1:0] exp_menor;
   logic [LARG_EXP-1:0] diff;

   // NOTE: every output is assigned on every path, so no latches are inferred.
   always_comb begin
      troca       = expoente_de(op_b) > expoente_de(op_a);
      maior       = troca ? op_b : op_a;
      menor       = troca ? op_a : op_b;
      sinal_maior = sinal_de(maior);
      sinal_menor = sinal_de(menor);
      exp_maior   = expoente_de(maior);
      exp_menor   = expoente_de(menor);
      diff        = exp_maior - exp_menor;
      if (diff > LARG_EXP'(MAX_DESLOC))
         cont = LARG_CONT'(MAX_DESLOC);
      else
         cont = diff[LARG_CONT-1:0];
      // Hidden bit is 0 for subnormals (exponent field zero).
      mant_maior  = {1'b0, exp_maior != '0, fracao_de(maior)};
      mant_menor  = {1'b0, exp_menor != '0, fracao_de(menor)};
   end

endmodule

// File: rtl/alinha_mantissa.sv
// Pre-add alignment stage: latches two fp16 operands, then shifts the smaller
// mantissa right one bit per clock until it lines up with the larger one.
module alinha_mantissa
   import fp16_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  inicio,
   input  logic [LARG_FP-1:0]    operando_A,
   input  logic [LARG_FP-1:0]    operando_B,
   output logic                  ocupado,
   output logic                  pronto,
   output logic                  troca,
   output logic                  sinal_Maior,
   output logic                  sinal_Menor,
   output logic [LARG_EXP-1:0]   expoente_Maior,
   output logic [LARG_MANT+1:0]  mantissa_Maior,
   output logic [LARG_MANT+1:0]  mantissa_Menor,
   output logic                  sticky
);

   estado_t               estado;
   logic [LARG_FP-1:0]    reg_a;
   logic [LARG_FP-1:0]    reg_b;
   logic [LARG_CONT-1:0]  cont;

   logic                  c_troca;
   logic                  c_sinal_maior;
   logic                  c_sinal_menor;
   logic [LARG_EXP-1:0]   c_exp_maior;
   logic [LARG_MANT+1:0]  c_mant_maior;
   logic [LARG_MANT+1:0]  c_mant_menor;
   logic [LARG_CONT-1:0]  c_cont;

   compara_expoente u_compara (
      .op_a        (reg_a),
      .op_b        (reg_b),
      .troca       (c_troca),
      .sinal_maior (c_sinal_maior),
      .sinal_menor (c_sinal_menor),
      .exp_maior   (c_exp_maior),
      .mant_maior  (c_mant_maior),
      .mant_menor  (c_mant_menor),
      .cont        (c_cont)
   );

   // NOTE: state and outputs update with non-blocking assignments so every
   // register samples its pre-edge value, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado         <= IDLE;
         reg_a          <= '0;
         reg_b          <= '0;
         cont           <= '0;
         ocupado        <= 1'b0;
         pronto         <= 1'b0;
         troca          <= 1'b0;
         sinal_Maior    <= 1'b0;
         sinal_Menor    <= 1'b0;
         expoente_Maior <= '0;
         mantissa_Maior <= '0;
         mantissa_Menor <= '0;
         sticky         <= 1'b0;
      end else begin
         pronto <= 1'b0;
         unique case (estado)
            IDLE: begin
               // The cycle showing pronto is the tail of the last operation.
               if (inicio && !pronto) begin
                  reg_a   <= operando_A;
                  reg_b   <= operando_B;
                  ocupado <= 1'b1;
                  estado  <= COMPARA;
               end
            end
            COMPARA: begin
               troca          <= c_troca;
               sinal_Maior    <= c_sinal_maior;
               sinal_Menor    <= c_sinal_menor;
               expoente_Maior <= c_exp_maior;
               mantissa_Maior <= c_mant_maior;
               mantissa_Menor <= c_mant_menor;
               sticky         <= 1'b0;
               cont           <= c_cont;
               estado         <= (c_cont != '0) ? DESLOCA : PRONTO;
            end
            DESLOCA: begin
               mantissa_Menor <= mantissa_Menor >> 1;
               sticky         <= sticky | mantissa_Menor[0];
               cont           <= cont - 1'b1;
               if (cont == LARG_CONT'(1))
                  estado <= PRONTO;
            end
            PRONTO: begin
               pronto  <= 1'b1;
               ocupado <= 1'b0;
               estado  <= IDLE;
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alinha_mantissa.sv
// Directed-vector bench for alinha_mantissa: latency, aligned results,
// ignored restarts and mid-operation reset.
module tb_alinha_mantissa;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        inicio;
   logic [15:0] operando_A;
   logic [15:0] operando_B;
   logic        ocupado;
   logic        pronto;
   logic        troca;
   logic        sinal_Maior;
   logic        sinal_Menor;
   logic [4:0]  expoente_Maior;
   logic [11:0] mantissa_Maior;
   logic [11:0] mantissa_Menor;
   logic        sticky;

   int checks = 0;
   int errors = 0;

   alinha_mantissa dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .inicio         (inicio),
      .operando_A     (operando_A),
      .operando_B     (operando_B),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .troca          (troca),
      .sinal_Maior    (sinal_Maior),
      .sinal_Menor    (sinal_Menor),
      .expoente_Maior (expoente_Maior),
      .mantissa_Maior (mantissa_Maior),
      .mantissa_Menor (mantissa_Menor),
      .sticky         (sticky)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Present operands with inicio for one edge; returns at cycle 0 (#1 after the sampling edge).
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clock);
      operando_A = a;
      operando_B = b;
      inicio     = 1'b1;
      @(posedge clock);
      #1;
      inicio     = 1'b0;
   endtask

   // Cycles after the sampling edge until pronto is seen; -1 if the budget expires.
   task automatic wait_pronto(output int lat);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clock);
         #1;
         if (pronto) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int lat_exp, input logic troca_exp,
                           input logic sm_exp, input logic sn_exp, input logic [4:0] e_exp,
                           input logic [11:0] mm_exp, input logic [11:0] mn_exp,
                           input logic st_exp);
      int lat;
      start(a, b);
      check({tag, "_ocupado"}, 32'(ocupado), 32'd1);
      wait_pronto(lat);
      check({tag, "_latencia"}, 32'(lat), 32'(lat_exp));
      check({tag, "_troca"}, 32'(troca), 32'(troca_exp));
      check({tag, "_sinal_Maior"}, 32'(sinal_Maior), 32'(sm_exp));
      check({tag, "_sinal_Menor"}, 32'(sinal_Menor), 32'(sn_exp));
      check({tag, "_expoente"}, 32'(expoente_Maior), 32'(e_exp));
      check({tag, "_mant_Maior"}, 32'(mantissa_Maior), 32'(mm_exp));
      check({tag, "_mant_Menor"}, 32'(mantissa_Menor), 32'(mn_exp));
      check({tag, "_sticky"}, 32'(sticky), 32'(st_exp));
      check({tag, "_ocupado_fim"}, 32'(ocupado), 32'd0);
      @(posedge clock);
      #1;
      check({tag, "_pronto_pulso"}, 32'(pronto), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
      check({tag, "_pronto"}, 32'(pronto), 32'd0);
      check({tag, "_troca"}, 32'(troca), 32'd0);
      check({tag, "_sinais"}, 32'({sinal_Maior, sinal_Menor}), 32'd0);
      check({tag, "_expoente"}, 32'(expoente_Maior), 32'd0);
      check({tag, "_mant_Maior"}, 32'(mantissa_Maior), 32'd0);
      check({tag, "_mant_Menor"}, 32'(mantissa_Menor), 32'd0);
      check({tag, "_sticky"}, 32'(sticky), 32'd0);
   endtask

   initial begin
      int n_pronto;
      int first_pronto;
      int ocup_late;

      reset_n    = 1'b0;
      inicio     = 1'b0;
      operando_A = 16'h0000;
      operando_B = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      //        tag     A        B        lat tr sM sm exp    mMaior   mMenor   st
      run_case("dif0",  16'h3C00, 16'hBC00, 2, 0, 0, 1, 5'd15, 12'h400, 12'h400, 0);
      run_case("dif3",  16'h4800, 16'h3E00, 5, 0, 0, 0, 5'd18, 12'h400, 12'h0C0, 0);
      run_case("troca", 16'h3800, 16'h3C00, 3, 1, 0, 0, 5'd15, 12'h400, 12'h200, 0);
      run_case("dif15", 16'h7800, 16'h3C01, 14, 0, 0, 0, 5'd30, 12'h400, 12'h000, 1);
      run_case("subn",  16'h0001, 16'h8400, 3, 1, 1, 0, 5'd1,  12'h400, 12'h000, 1);

      // Restart requests while busy and during pronto must be dropped.
      start(16'h4800, 16'h3E00);
      n_pronto     = 0;
      first_pronto = -1;
      ocup_late    = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clock);
         #1;
         inicio = (k == 2 || k == 5);
         if (pronto) begin
            n_pronto++;
            if (first_pronto < 0) first_pronto = k;
         end
         if (k >= 6 && ocupado) ocup_late++;
      end
      inicio = 1'b0;
      check("reinicio_n_pronto", 32'(n_pronto), 32'd1);
      check("reinicio_ciclo", 32'(first_pronto), 32'd5);
      check("reinicio_ocupado", 32'(ocup_late), 32'd0);

      // Reset in the middle of a long alignment.
      start(16'h7800, 16'h3C01);
      repeat (5) @(posedge clock);
      #1;
      check("pre_reset_sticky", 32'(sticky), 32'd1);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check_all_zero("meio_reset");
      reset_n  = 1'b1;
      n_pronto = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock);
         #1;
         if (pronto) n_pronto++;
      end
      check("pos_reset_sem_pronto", 32'(n_pronto), 32'd0);

      run_case("pos_reset", 16'h3C00, 16'hBC00, 2, 0, 0, 1, 5'd15, 12'h400, 12'h400, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alinha_mantissa.md
Name: alinha_mantissa

Overview:
Pre-add alignment stage for the half-precision (1/5/10) adder datapath. It is the counterpart of the post-add normalizer.
- Takes two operands and identifies the one with the larger exponent.
- Restores hidden bits.
- Shifts the smaller operand's mantissa right by the exponent difference, one bit per clock.
- Delivers both 12-bit mantissas in the format the normalizer expects: bit 11 carry guard, bit 10 hidden, bits 9:0 fraction.
- Start/done handshake with the adder controller.

Parameters:
LARG_EXP, 5, exponent width
LARG_MANT, 10, stored fraction width
MAX_DESLOC, 12, shift-count cap; any larger difference flushes the smaller mantissa to zero

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
inicio  input  1  start request, sampled in IDLE only
operando_A  input  16  half-precision operand A {sinal, exp[4:0], mant[9:0]}
operando_B  input  16  half-precision operand B
ocupado  output  1  high while not in IDLE
pronto  output  1  one-cycle pulse: outputs valid
troca  output  1  1 = B had the larger exponent (operands swapped)
sinal_Maior  output  1  sign of the larger-exponent operand
sinal_Menor  output  1  sign of the smaller-exponent operand
expoente_Maior  output  5  larger exponent, passed through unchanged
mantissa_Maior  output  12  {0, hidden, mant} of the larger operand
mantissa_Menor  output  12  aligned {0, hidden, mant} of the smaller operand
sticky  output  1  OR of all 1-bits shifted out of mantissa_Menor

Behaviour:
- Reset: reset_n low at a rising edge forces IDLE; all outputs become 0 on that edge. Applies in any state. An operation in flight is abandoned and no pronto is issued.
- Hidden bit = 1 when the exponent is non-zero, 0 otherwise (subnormal). Bit 11 is always 0 on output.
- IDLE:
  - ocupado = 0.
  - On inicio = 1: latch both operands, go to COMPARA.
  - The outputs keep their last result until the COMPARA of the next operation.
- COMPARA (1 cycle):
  - If exp_B > exp_A: troca = 1 and the operands are swapped. On equal exponents A is the larger; no mantissa comparison is made.
  - Load expoente_Maior, sinal_Maior/Menor and both mantissas; clear sticky.
  - cont = min(exp_Maior − exp_Menor, MAX_DESLOC), computed as an unsigned 5-bit difference.
  - Go to DESLOCA if cont ≠ 0, else to PRONTO.
- DESLOCA:
  - Each cycle: mantissa_Menor >>= 1 with 0 shifted in; sticky |= the old bit 0; cont −= 1.
  - When cont reaches 0 after the shift, go to PRONTO.
- PRONTO: pronto = 1 for exactly this cycle, then go to IDLE.
- Latency: pronto goes high 2 + cont cycles after the edge that sampled inicio. Minimum 2, maximum 14.
- inicio while ocupado = 1: ignored, not queued. inicio in the same cycle as pronto: ignored. The next accept is possible in the IDLE cycle after PRONTO.
- A difference ≥ 12 yields mantissa_Menor = 0. sticky is set if the original mantissa was non-zero.
- Inf/NaN (exp = 31) is not special-cased; the operand is treated as an ordinary value.
- Operands are latched at accept, so changes on operando_A/B during operation have no effect.

Decomposition:
- Shared package fp16_pkg holds:
  - constants LARG_EXP, LARG_MANT, MAX_DESLOC;
  - the state enum {IDLE, COMPARA, DESLOCA, PRONTO};
  - field-extract helpers for sign, exponent and fraction.
- Package also used by the normalizer and the adder controller.
- One natural sub-module: compara_expoente. It is combinational: swap decision, saturated difference and hidden-bit insertion.

Test Plan:
- A=0x3C00, B=0xBC00 (diff 0), inicio pulse -> pronto at cycle 2; troca=0, expoente_Maior=15, mantissa_Maior=0x400, mantissa_Menor=0x400, sinal_Menor=1, sticky=0.
- A=0x4800, B=0x3E00 (diff 3) -> pronto at cycle 5; mantissa_Maior=0x400, mantissa_Menor=0x0C0, sticky=0, expoente_Maior=18.
- A=0x3800, B=0x3C00 -> troca=1, expoente_Maior=15, mantissa_Maior=0x400, mantissa_Menor=0x200, pronto at cycle 3.
- A=0x7800, B=0x3C01 (diff 15, capped at 12) -> pronto at cycle 14; mantissa_Menor=0x000, sticky=1.
- Start diff-3 case, pulse inicio again at cycles 2 and 5 -> single pronto at cycle 5; no second operation starts.
- Start diff-15 case, drive reset_n=0 at cycle 6 for one edge -> ocupado=0, all outputs 0, no pronto. A fresh inicio afterwards completes normally.
